// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-decode stage.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_J    = 3'd4,
        FMT_U    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the format from the opcode and
// extracts/extends the immediate to XLEN bits.
module imm_gen
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt
);

    // Every format fits in 32 bits; bit 31 carries the sign for the wider case.
    logic [31:0] imm32;

    // Opcode to format, then bit placement for that format.
    always_comb begin
        fmt   = FMT_NONE;
        imm32 = '0;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_STORE:                      fmt = FMT_S;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = FMT_I;
            // Word-sized ALU ops only exist on the 64-bit machine.
            OPC_OP_IMM_32:                  fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            // CSR immediate forms (funct3[2]=1) carry a 5-bit zimm.
            OPC_SYSTEM:                     fmt = inst[14] ? FMT_Z : FMT_I;
            default:                        fmt = FMT_NONE;
        endcase
        case (fmt)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_Z:   imm32 = {27'b0, inst[19:15]};
            default: imm32 = '0;
        endcase
    end

    // Z and NONE have bit 31 clear, so one sign-extension covers all formats.
    if (XLEN == 64) begin : g_ext64
        assign imm = {{32{imm32[31]}}, imm32};
    end else begin : g_ext32
        assign imm = imm32;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: one-cycle latency, two-entry skid buffer
// (main feeds out_*, skid absorbs one extra entry under backpressure).
// Handshake: a transfer happens on a cycle where valid and ready are both 1
// at the rising edge; valid never depends on ready, and in_ready is a
// register output (high whenever the skid entry is empty).
// Optional feature: define IMM_DECODE_PERF_EN to build the accept counter
// behind perf_cnt; otherwise perf_cnt is tied to zero.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_t         out_fmt,
    output logic [31:0]      out_inst,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      perf_cnt
);

    logic [XLEN-1:0]  gen_imm;
    imm_fmt_t         gen_fmt;

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  main_imm_q,  skid_imm_q;
    imm_fmt_t         main_fmt_q,  skid_fmt_q;
    logic [31:0]      main_inst_q, skid_inst_q;
    logic [TAG_W-1:0] main_tag_q,  skid_tag_q;

    logic             accept;
    logic             retire;
    logic             main_load_new;
    logic             main_load_skid;
    logic             skid_load;

    // Decode happens on the way in; buffers store the decoded result.
    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (in_inst),
        .imm  (gen_imm),
        .fmt  (gen_fmt)
    );

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_imm   = main_imm_q;
    assign out_fmt   = main_fmt_q;
    assign out_inst  = main_inst_q;
    assign out_tag   = main_tag_q;

    // A flushed accept is dropped outright, so it neither fills nor counts.
    assign accept = in_valid & in_ready & ~flush;
    assign retire = main_valid_q & out_ready;

    // Occupancy control: decide which entries load and which valids change.
    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        main_load_new  = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d  = 1'b1;
                main_load_new = 1'b1;
            end
        end else if (skid_valid_q) begin
            // Full: in_ready is low, so only a retire can change anything.
            if (retire) begin
                main_load_skid = 1'b1;
                skid_valid_d   = 1'b0;
            end
        end else begin
            if (retire && accept) begin
                main_load_new = 1'b1;        // pass-through, no bubble
            end else if (retire) begin
                main_valid_d  = 1'b0;
            end else if (accept) begin
                skid_valid_d  = 1'b1;
                skid_load     = 1'b1;
            end
        end
    end

    // Valid flags; reset drops both entries immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Main entry payload: new decode or promoted skid entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_imm_q  <= '0;
            main_fmt_q  <= FMT_NONE;
            main_inst_q <= '0;
            main_tag_q  <= '0;
        end else if (main_load_new) begin
            main_imm_q  <= gen_imm;
            main_fmt_q  <= gen_fmt;
            main_inst_q <= in_inst;
            main_tag_q  <= in_tag;
        end else if (main_load_skid) begin
            main_imm_q  <= skid_imm_q;
            main_fmt_q  <= skid_fmt_q;
            main_inst_q <= skid_inst_q;
            main_tag_q  <= skid_tag_q;
        end
    end

    // Skid entry payload: captures an accept while main is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_imm_q  <= '0;
            skid_fmt_q  <= FMT_NONE;
            skid_inst_q <= '0;
            skid_tag_q  <= '0;
        end else if (skid_load) begin
            skid_imm_q  <= gen_imm;
            skid_fmt_q  <= gen_fmt;
            skid_inst_q <= in_inst;
            skid_tag_q  <= in_tag;
        end
    end

`ifdef IMM_DECODE_PERF_EN
    logic [31:0] perf_q;

    // Count accepted instructions that carry an immediate; wraps, survives flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if (accept && (gen_fmt != FMT_NONE)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cnt = perf_q;
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: one 32-bit and one 64-bit instance share the
// stimulus; a queue model tracks occupancy and a reference decoder computes
// expected immediates from the instruction-set bit layout.
module tb_imm_decode_stage;
    import imm_pkg::*;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] tag;
        logic [2:0]  fmt32;
        logic [31:0] imm32;
        logic [2:0]  fmt64;
        logic [63:0] imm64;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        ir32, ov32, ir64, ov64;
    logic [31:0] imm32_o, inst32_o, tag32_o, perf32;
    logic [63:0] imm64_o;
    logic [31:0] inst64_o, tag64_o, perf64;
    imm_fmt_t    fmt32_o, fmt64_o;

    entry_t      exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          retire_cnt = 0;
    int          ir_low_cnt = 0;
    logic [31:0] exp_perf32 = 0;
    logic [31:0] exp_perf64 = 0;

    imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir32), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32_o), .out_fmt(fmt32_o),
        .out_inst(inst32_o), .out_tag(tag32_o), .perf_cnt(perf32)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir64), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64_o), .out_fmt(fmt64_o),
        .out_inst(inst64_o), .out_tag(tag64_o), .perf_cnt(perf64)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Reference decode: the immediate's numeric value from the ISA layout.
    function automatic void ref_decode(input logic [31:0] w, input int xlen,
                                       output logic [2:0] fmt, output logic [63:0] imm);
        longint      v;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [11:0] s12;
        v   = 0;
        fmt = FMT_NONE;
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        s12 = {w[31:25], w[11:7]};
        case (w[6:0])
            7'h37, 7'h17: begin fmt = FMT_U; v = longint'($signed(w[31:12])) * 4096; end
            7'h6F:        begin fmt = FMT_J; v = longint'($signed(j21)); end
            7'h63:        begin fmt = FMT_B; v = longint'($signed(b13)); end
            7'h23:        begin fmt = FMT_S; v = longint'($signed(s12)); end
            7'h03, 7'h13, 7'h67: begin fmt = FMT_I; v = longint'($signed(w[31:20])); end
            7'h1B: if (xlen == 64) begin fmt = FMT_I; v = longint'($signed(w[31:20])); end
            7'h73: if (w[14]) begin fmt = FMT_Z; v = longint'(w[19:15]); end
                   else begin fmt = FMT_I; v = longint'($signed(w[31:20])); end
            default: ;
        endcase
        imm = v;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h13, 7'h67, 7'h1B, 7'h73, 7'h33, 7'h7F};
        w = $urandom();
        w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    function automatic logic [31:0] perf_expect(input logic [31:0] cnt);
`ifdef IMM_DECODE_PERF_EN
        return cnt;
`else
        return (cnt & 32'h0);
`endif
    endfunction

    // Driver + scoreboard: one clock cycle of stimulus, checks outputs at the
    // falling edge, then advances the model for the coming rising edge.
    task automatic drive_cycle(input logic v, input logic [31:0] inst, input logic [31:0] tag,
                               input logic fl, input logic ordy);
        entry_t e;
        logic   acc, ret;
        in_valid = v; in_inst = inst; in_tag = tag; flush = fl; out_ready = ordy;
        @(negedge clk);
        checks++;
        if (ov32 !== (exp_q.size() > 0) || ov64 !== (exp_q.size() > 0)) begin
            failures++;
            $display("FAIL out_valid: got %b/%b want %b", ov32, ov64, exp_q.size() > 0);
        end
        checks++;
        if (ir32 !== (exp_q.size() < 2) || ir64 !== (exp_q.size() < 2)) begin
            failures++;
            $display("FAIL in_ready: got %b/%b want %b", ir32, ir64, exp_q.size() < 2);
        end
        if (ir32 === 1'b0) ir_low_cnt++;
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            checks++;
            if (inst32_o !== e.inst || tag32_o !== e.tag || inst64_o !== e.inst || tag64_o !== e.tag) begin
                failures++;
                $display("FAIL passthru: got inst %h/%h tag %h/%h want inst %h tag %h",
                         inst32_o, inst64_o, tag32_o, tag64_o, e.inst, e.tag);
            end
            checks++;
            if (fmt32_o !== e.fmt32 || imm32_o !== e.imm32) begin
                failures++;
                $display("FAIL decode32 inst %h: got fmt %0d imm %h want fmt %0d imm %h",
                         e.inst, fmt32_o, imm32_o, e.fmt32, e.imm32);
            end
            checks++;
            if (fmt64_o !== e.fmt64 || imm64_o !== e.imm64) begin
                failures++;
                $display("FAIL decode64 inst %h: got fmt %0d imm %h want fmt %0d imm %h",
                         e.inst, fmt64_o, imm64_o, e.fmt64, e.imm64);
            end
        end
        checks++;
        if (perf32 !== perf_expect(exp_perf32) || perf64 !== perf_expect(exp_perf64)) begin
            failures++;
            $display("FAIL perf_cnt: got %0d/%0d want %0d/%0d", perf32, perf64,
                     perf_expect(exp_perf32), perf_expect(exp_perf64));
        end
        acc = v && (exp_q.size() < 2) && !fl;
        ret = (exp_q.size() > 0) && ordy;
        if (ret) retire_cnt++;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (ret) void'(exp_q.pop_front());
            if (acc) begin
                e.inst = inst; e.tag = tag;
                ref_decode(inst, 32, e.fmt32, e.imm64);
                e.imm32 = e.imm64[31:0];
                ref_decode(inst, 64, e.fmt64, e.imm64);
                exp_q.push_back(e);
                if (e.fmt32 != FMT_NONE) exp_perf32 = exp_perf32 + 1;
                if (e.fmt64 != FMT_NONE) exp_perf64 = exp_perf64 + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov32 !== 1'b0 || ov64 !== 1'b0 || ir32 !== 1'b1 || ir64 !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: got ov %b/%b ir %b/%b want ov 0 ir 1", ov32, ov64, ir32, ir64);
        end
        checks++;
        if (imm32_o !== 32'h0 || imm64_o !== 64'h0 || fmt32_o !== FMT_NONE || fmt64_o !== FMT_NONE ||
            inst32_o !== 32'h0 || tag32_o !== 32'h0 || inst64_o !== 32'h0 || tag64_o !== 32'h0 ||
            perf32 !== 32'h0 || perf64 !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got imm %h/%h fmt %0d/%0d inst %h tag %h perf %0d want zeros",
                     imm32_o, imm64_o, fmt32_o, fmt64_o, inst32_o, tag32_o, perf32);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); exp_perf32 = 0; exp_perf64 = 0;
    endtask

    task automatic test_directed();
        drive_cycle(1'b1, 32'hFFF00093, 32'h1000, 1'b0, 1'b1);
        checks++;
        if (fmt32_o !== FMT_I || imm32_o !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL addi32: got fmt %0d imm %h want fmt 1 imm ffffffff", fmt32_o, imm32_o);
        end
        drive_cycle(1'b1, 32'h800000EF, 32'h1004, 1'b0, 1'b1);
        checks++;
        if (fmt64_o !== FMT_J || imm64_o !== 64'hFFFFFFFFFFF00000) begin
            failures++;
            $display("FAIL jal64: got fmt %0d imm %h want fmt 4 imm fffffffffff00000", fmt64_o, imm64_o);
        end
        drive_cycle(1'b1, 32'h0000A0F3, 32'h1008, 1'b0, 1'b1);
        checks++;
        if (fmt64_o !== FMT_I || imm64_o !== 64'h0) begin
            failures++;
            $display("FAIL csrrs64: got fmt %0d imm %h want fmt 1 imm 0", fmt64_o, imm64_o);
        end
        drive_cycle(1'b1, 32'h0000E0F3, 32'h100C, 1'b0, 1'b1);
        checks++;
        if (fmt64_o !== FMT_Z || imm64_o !== 64'h1) begin
            failures++;
            $display("FAIL csrrsi64: got fmt %0d imm %h want fmt 6 imm 1", fmt64_o, imm64_o);
        end
        drive_cycle(1'b1, 32'hFFF0009B, 32'h1010, 1'b0, 1'b1);
        checks++;
        if (fmt32_o !== FMT_NONE || imm32_o !== 32'h0 || fmt64_o !== FMT_I || imm64_o !== '1) begin
            failures++;
            $display("FAIL addiw: got fmt %0d/%0d imm %h/%h want fmt 0/1 imm 0/all-ones",
                     fmt32_o, fmt64_o, imm32_o, imm64_o);
        end
        idle(1);
    endtask

    task automatic test_backpressure();
        int r0;
        r0 = retire_cnt;
        drive_cycle(1'b1, 32'h00100093, 32'hA, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00200093, 32'hB, 1'b0, 1'b0);
        checks++;
        if (ir32 !== 1'b0 || ov32 !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: got ir %b ov %b want ir 0 ov 1", ir32, ov32);
        end
        drive_cycle(1'b1, 32'h00300093, 32'hC, 1'b0, 1'b0);
        checks++;
        if (ir32 !== 1'b0 || inst32_o !== 32'h00100093) begin
            failures++;
            $display("FAIL bp_hold: got ir %b inst %h want ir 0 inst 00100093", ir32, inst32_o);
        end
        drive_cycle(1'b1, 32'h00300093, 32'hC, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h00300093, 32'hC, 1'b0, 1'b1);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (retire_cnt - r0 != 3 || ov32 !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: got retires %0d ov %b want 3 and 0", retire_cnt - r0, ov32);
        end
    endtask

    task automatic test_back_to_back();
        int r0, l0;
        r0 = retire_cnt; l0 = ir_low_cnt;
        for (int i = 0; i < 100; i++) drive_cycle(1'b1, rand_inst(), $urandom(), 1'b0, 1'b1);
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (retire_cnt - r0 != 100 || ir_low_cnt != l0) begin
            failures++;
            $display("FAIL b2b: got retires %0d ready_low %0d want 100 and 0", retire_cnt - r0, ir_low_cnt - l0);
        end
    endtask

    task automatic test_flush();
        logic [31:0] p32;
        drive_cycle(1'b1, 32'h00400093, 32'h11, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00500093, 32'h12, 1'b0, 1'b0);
        p32 = exp_perf32;
        drive_cycle(1'b1, 32'h00600093, 32'h13, 1'b1, 1'b0);
        checks++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1 || ov64 !== 1'b0 || perf32 !== perf_expect(p32)) begin
            failures++;
            $display("FAIL flush: got ov %b ir %b perf %0d want ov 0 ir 1 perf %0d",
                     ov32, ir32, perf32, perf_expect(p32));
        end
        idle(2);
    endtask

    task automatic test_perf();
        logic [31:0] p32;
        logic [31:0] seq [5];
        seq = '{32'h00700093, 32'h123450B7, 32'h002081B3, 32'h00112023, 32'h008000EF};
        p32 = exp_perf32;
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, seq[i], 32'h20 + i, 1'b0, 1'b1);
        idle(1);
        checks++;
        if (perf32 !== perf_expect(p32 + 32'd4)) begin
            failures++;
            $display("FAIL perf5: got %0d want %0d", perf32, perf_expect(p32 + 32'd4));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            drive_cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
                        $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        idle(3);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 32'h00800093, 32'h31, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00900093, 32'h32, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1 || ov64 !== 1'b0 || perf32 !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got ov %b ir %b perf %0d want 0 1 0", ov32, ir32, perf32);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); exp_perf32 = 0; exp_perf64 = 0;
        idle(2);
        checks++;
        if (ov32 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: got ov %b want 0", ov32);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_perf();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
